// File: rtl/bsg_fifo_1rw_large_sched.sv
// bsg_fifo_1rw_large_sched
// Drives the single read/write port of a large 1rw FIFO so that it behaves
// like a streaming FIFO. Each cycle at most one of enqueue/dequeue is issued.
// Contention is resolved round-robin. A 2-entry output buffer hides the
// FIFO's one-cycle read latency. Dequeues are only issued while a buffer slot
// is guaranteed to be free, counting the read still in flight. When the FIFO
// is empty and nothing is in flight, upstream words may skip the FIFO and go
// straight into the output buffer.
module bsg_fifo_1rw_large_sched #(
    parameter int width_p  = 8,
    parameter bit bypass_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               yumi_o,

    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,

    output logic               fifo_v_o,
    output logic               fifo_enq_not_deq_o,
    output logic [width_p-1:0] fifo_data_o,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    input  logic [width_p-1:0] fifo_data_i
);

    typedef enum logic {
        GRANT_DEQ = 1'b0,
        GRANT_ENQ = 1'b1
    } grant_e;

    // Scheduler state
    logic [1:0]   obuf_count;
    logic         inflight;
    grant_e       last_grant;

    // Output buffer storage, organised as a 2-entry circular queue
    logic [width_p-1:0] obuf_mem [2];
    logic               obuf_rd_ptr;
    logic               obuf_wr_ptr;

    // Per-cycle decisions
    logic               bypass;
    logic               enq_elig;
    logic               deq_elig;
    logic               enq_grant;
    logic               deq_grant;
    logic [1:0]         credit_used;
    logic               obuf_wr;
    logic               obuf_pop;
    logic [width_p-1:0] obuf_wr_data;

    // Slots already promised: words held plus the read currently returning.
    assign credit_used = obuf_count + {1'b0, inflight};

    // Pick bypass, enqueue, dequeue or nothing for this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        bypass    = 1'b0;
        enq_grant = 1'b0;
        deq_grant = 1'b0;
        enq_elig  = v_i & ~fifo_full_i;
        deq_elig  = ~fifo_empty_i & (credit_used < 2'd2);
        if (!reset_i) begin
            // Empty FIFO and nothing in flight means every older word is
            // already in the output buffer, so skipping the FIFO keeps order.
            bypass = bypass_p && v_i && fifo_empty_i && !inflight
                     && (obuf_count != 2'd2);
            if (!bypass) begin
                if (enq_elig && deq_elig) begin
                    enq_grant = (last_grant == GRANT_DEQ);
                    deq_grant = (last_grant == GRANT_ENQ);
                end else begin
                    enq_grant = enq_elig;
                    deq_grant = deq_elig;
                end
            end
        end
    end

    assign yumi_o             = bypass | enq_grant;
    assign fifo_v_o           = enq_grant | deq_grant;
    assign fifo_enq_not_deq_o = enq_grant;
    assign fifo_data_o        = data_i;

    // Bypass and capture never coincide: bypass requires nothing in flight.
    assign obuf_wr      = bypass | inflight;
    assign obuf_wr_data = inflight ? fifo_data_i : data_i;
    assign obuf_pop     = yumi_i & v_o;

    assign v_o    = (obuf_count != 2'd0);
    assign data_o = obuf_mem[obuf_rd_ptr];

    // Scheduler and output-buffer bookkeeping.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset_i) begin
            obuf_count  <= 2'd0;
            obuf_rd_ptr <= 1'b0;
            obuf_wr_ptr <= 1'b0;
            inflight    <= 1'b0;
            last_grant  <= GRANT_DEQ;
        end else begin
            obuf_count <= obuf_count + 2'(obuf_wr) - 2'(obuf_pop);
            if (obuf_wr) begin
                obuf_wr_ptr <= ~obuf_wr_ptr;
            end
            if (obuf_pop) begin
                obuf_rd_ptr <= ~obuf_rd_ptr;
            end
            // A capture clears the flag unless a new read replaces it.
            inflight <= deq_grant;
            if (enq_grant) begin
                last_grant <= GRANT_ENQ;
            end else if (deq_grant) begin
                last_grant <= GRANT_DEQ;
            end
        end
    end

    // Output buffer data storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the count and pointers
        // decide which entries are meaningful.
        if (obuf_wr && !reset_i) begin
            obuf_mem[obuf_wr_ptr] <= obuf_wr_data;
        end
    end

    // Simulation-only protocol checks.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("yumi_i asserted while v_o is low");
            assert (!(obuf_wr && !obuf_pop && obuf_count == 2'd2))
                else $error("output buffer overflow");
        end
    end

endmodule

// File: tb/tb_bsg_fifo_1rw_large_sched.sv
// Bench for bsg_fifo_1rw_large_sched. Two instances run side by side:
// u[0] with bypass enabled, u[1] with bypass disabled. Each has its own
// behavioural 1rw FIFO and a queue-based reference model checked every cycle.
module tb_bsg_fifo_1rw_large_sched;

    localparam int W   = 8;
    localparam int ELS = 8;

    logic       clk;
    logic       reset;
    logic       want_pop;
    logic [7:0] src_base;
    int         src_n;
    int         burst_id;
    int         checks;
    int         errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam bit BYP = (g == 0);

        logic [W-1:0] data_i, data_o, fifo_data_o;
        logic         v_i, yumi_o, v_o, yumi_i, fifo_v_o, fifo_enq_not_deq_o;
        logic         f_full = 1'b0;
        logic         f_empty = 1'b1;
        logic [W-1:0] f_data = '0;
        logic [W-1:0] f_q[$];

        // Reference model state
        logic [W-1:0] m_obuf[$];
        logic [W-1:0] m_fifo[$];
        logic [W-1:0] m_pend;
        bit           m_inflight, m_last_enq, m_live;
        int           m_cnt, m_sent;

        bsg_fifo_1rw_large_sched #(.width_p(W), .bypass_p(BYP)) dut (
            .clk_i              (clk),
            .reset_i            (reset),
            .data_i             (data_i),
            .v_i                (v_i),
            .yumi_o             (yumi_o),
            .v_o                (v_o),
            .data_o             (data_o),
            .yumi_i             (yumi_i),
            .fifo_v_o           (fifo_v_o),
            .fifo_enq_not_deq_o (fifo_enq_not_deq_o),
            .fifo_data_o        (fifo_data_o),
            .fifo_full_i        (f_full),
            .fifo_empty_i       (f_empty),
            .fifo_data_i        (f_data)
        );

        // Behavioural single-port FIFO with registered flags and read data.
        always @(posedge clk) begin
            if (reset) begin
                f_q.delete();
                f_full  <= 1'b0;
                f_empty <= 1'b1;
            end else begin
                if (fifo_v_o && fifo_enq_not_deq_o && f_q.size() < ELS)
                    f_q.push_back(fifo_data_o);
                if (fifo_v_o && !fifo_enq_not_deq_o && f_q.size() != 0)
                    f_data <= f_q.pop_front();
                f_full  <= (f_q.size() == ELS);
                f_empty <= (f_q.size() == 0);
            end
        end

        // Upstream source and downstream sink, driven well after the edge.
        initial begin
            int seen;
            seen   = 0;
            v_i    = 1'b0;
            data_i = '0;
            yumi_i = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                if (burst_id != seen) begin
                    seen   = burst_id;
                    m_sent = 0;
                end
                v_i    = (m_sent < src_n);
                data_i = src_base + 8'(m_sent);
                yumi_i = want_pop && (m_cnt != 0);
            end
        end

        // Reference model: compare this cycle's outputs, then advance.
        always @(negedge clk) begin
            bit full, empty, byp, enq_e, deq_e, g_enq, g_deq;
            if (reset) begin
                check($sformatf("u%0d reset yumi_o", g), yumi_o, 0);
                check($sformatf("u%0d reset fifo_v_o", g), fifo_v_o, 0);
                if (m_live) check($sformatf("u%0d reset v_o", g), v_o, m_obuf.size() != 0);
                m_obuf.delete();
                m_fifo.delete();
                m_inflight = 1'b0;
                m_last_enq = 1'b0;
                m_live     = 1'b1;
            end else if (m_live) begin
                full  = (m_fifo.size() == ELS);
                empty = (m_fifo.size() == 0);
                byp   = BYP && v_i && empty && !m_inflight && m_obuf.size() < 2;
                enq_e = v_i && !full;
                deq_e = !empty && (m_obuf.size() + int'(m_inflight) < 2);
                g_enq = 1'b0;
                g_deq = 1'b0;
                if (!byp) begin
                    if (enq_e && deq_e) begin
                        g_enq = !m_last_enq;
                        g_deq = m_last_enq;
                    end else begin
                        g_enq = enq_e;
                        g_deq = deq_e;
                    end
                end
                check($sformatf("u%0d v_o", g), v_o, m_obuf.size() != 0);
                if (m_obuf.size() != 0) check($sformatf("u%0d data_o", g), data_o, m_obuf[0]);
                check($sformatf("u%0d yumi_o", g), yumi_o, byp || g_enq);
                check($sformatf("u%0d fifo_v_o", g), fifo_v_o, g_enq || g_deq);
                if (g_enq || g_deq)
                    check($sformatf("u%0d fifo_enq_not_deq_o", g), fifo_enq_not_deq_o, g_enq);
                if (g_enq) check($sformatf("u%0d fifo_data_o", g), fifo_data_o, data_i);

                if (yumi_i && m_obuf.size() != 0) void'(m_obuf.pop_front());
                if (m_inflight) m_obuf.push_back(m_pend);
                if (byp) m_obuf.push_back(data_i);
                m_inflight = g_deq;
                if (g_deq) m_pend = m_fifo.pop_front();
                if (g_enq) m_fifo.push_back(data_i);
                if (g_enq || g_deq) m_last_enq = g_enq;
                if (byp || g_enq) m_sent++;
            end
            m_cnt = m_obuf.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [7:0] base, input int n);
        src_base = base;
        src_n    = n;
        burst_id++;
    endtask

    initial begin
        int exp;
        reset    = 1'b1;
        want_pop = 1'b0;
        src_base = '0;
        src_n    = 0;
        burst_id = 0;
        checks   = 0;
        errors   = 0;

        // Reset held with upstream valid: nothing accepted, nothing issued.
        burst(8'h3C, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t1 u0 yumi_o in reset", u[0].yumi_o, 0);
            check("t1 u0 fifo_v_o in reset", u[0].fifo_v_o, 0);
            check("t1 u0 v_o in reset", u[0].v_o, 0);
            check("t1 u1 yumi_o in reset", u[1].yumi_o, 0);
            check("t1 u1 fifo_v_o in reset", u[1].fifo_v_o, 0);
        end
        tick(); reset = 1'b0;
        @(negedge clk);
        check("t1 u0 bypass accept", u[0].yumi_o, 1);
        check("t1 u0 bypass no fifo op", u[0].fifo_v_o, 0);
        check("t1 u0 v_o after reset", u[0].v_o, 0);
        check("t1 u1 enq accept", u[1].yumi_o, 1);
        check("t1 u1 enq issued", u[1].fifo_enq_not_deq_o, 1);
        tick(); @(negedge clk);
        check("t1 u0 v_o", u[0].v_o, 1);
        check("t1 u0 data_o", u[0].data_o, 8'h3C);
        check("t1 u1 deq issued", u[1].fifo_v_o, 1);
        check("t1 u1 deq dir", u[1].fifo_enq_not_deq_o, 0);
        tick(); @(negedge clk);
        check("t1 u1 v_o t+2", u[1].v_o, 0);
        tick(); @(negedge clk);
        check("t1 u1 v_o t+3", u[1].v_o, 1);
        check("t1 u1 data_o t+3", u[1].data_o, 8'h3C);
        want_pop = 1'b1;
        repeat (4) tick();
        want_pop = 1'b0;
        tick();

        // Single word through the FIFO without bypass.
        tick(); burst(8'hA5, 1);
        @(negedge clk);
        check("t2 cyc0 fifo_v_o", u[1].fifo_v_o, 1);
        check("t2 cyc0 enq", u[1].fifo_enq_not_deq_o, 1);
        check("t2 cyc0 fifo_data_o", u[1].fifo_data_o, 8'hA5);
        tick(); @(negedge clk);
        check("t2 cyc1 fifo_v_o", u[1].fifo_v_o, 1);
        check("t2 cyc1 deq", u[1].fifo_enq_not_deq_o, 0);
        tick(); @(negedge clk);
        check("t2 cyc2 v_o", u[1].v_o, 0);
        tick(); @(negedge clk);
        check("t2 cyc3 v_o", u[1].v_o, 1);
        check("t2 cyc3 data_o", u[1].data_o, 8'hA5);
        want_pop = 1'b1;
        repeat (4) tick();
        want_pop = 1'b0;
        tick();

        // Preload, then stream with contention: grants alternate.
        tick(); burst(8'h20, 40);
        repeat (5) tick();
        tick(); want_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t3 u0 fifo_v_o %0d", i), u[0].fifo_v_o, 1);
            check($sformatf("t3 u0 alternate %0d", i), u[0].fifo_enq_not_deq_o, (i % 2 == 0));
            tick();
        end
        repeat (20) tick();
        burst(8'h00, 0);
        repeat (12) tick();

        // Fill everything with the sink stalled, then drain in order.
        reset = 1'b1; want_pop = 1'b0;
        tick(); tick(); reset = 1'b0;
        tick(); burst(8'h00, ELS + 2);
        repeat (ELS + 10) tick();
        @(negedge clk);
        check("t4 u0 v_o", u[0].v_o, 1);
        check("t4 u0 head", u[0].data_o, 8'h00);
        check("t4 u0 fifo full", u[0].f_full, 1);
        check("t4 u1 head", u[1].data_o, 8'h00);
        check("t4 u1 fifo full", u[1].f_full, 1);
        tick(); burst(8'h77, 1);
        @(negedge clk);
        check("t4 u0 blocked", u[0].yumi_o, 0);
        check("t4 u1 blocked", u[1].yumi_o, 0);
        tick(); @(negedge clk);
        check("t4 u0 still blocked", u[0].yumi_o, 0);
        want_pop = 1'b1;
        exp = 0;
        for (int c = 0; c < 60 && exp < ELS + 2; c++) begin
            tick(); @(negedge clk);
            if (u[0].yumi_i) begin
                check($sformatf("t4 drain word %0d", exp), u[0].data_o, exp);
                exp++;
            end
        end
        if (exp < ELS + 2) begin
            checks++; errors++;
            $display("FAIL t4 drain timeout popped=%0d expected=%0d", exp, ELS + 2);
        end
        repeat (6) tick();

        // Credit limit: one word held plus one in flight blocks dequeues.
        reset = 1'b1; want_pop = 1'b0; burst(8'h00, 0);
        tick(); tick(); reset = 1'b0;
        tick(); burst(8'h10, 4);
        repeat (5) tick();
        tick(); want_pop = 1'b1;
        @(negedge clk);
        check("t5 full obuf no deq", u[0].fifo_v_o, 0);
        tick(); want_pop = 1'b0;
        @(negedge clk);
        check("t5 slot free deq", u[0].fifo_v_o, 1);
        check("t5 slot free dir", u[0].fifo_enq_not_deq_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk);
            check($sformatf("t5 no credit %0d", i), u[0].fifo_v_o, 0);
        end
        tick(); want_pop = 1'b1;
        @(negedge clk);
        check("t5 no lookahead", u[0].fifo_v_o, 0);
        tick(); want_pop = 1'b0;
        @(negedge clk);
        check("t5 deq after pop", u[0].fifo_v_o, 1);
        check("t5 deq after pop dir", u[0].fifo_enq_not_deq_o, 0);
        check("t5 head order", u[0].data_o, 8'h12);

        // Reset with a word held and a read in flight.
        tick(); reset = 1'b1;
        @(negedge clk);
        check("t6 v_o during reset", u[0].v_o, 1);
        check("t6 yumi_o during reset", u[0].yumi_o, 0);
        tick(); reset = 1'b0; burst(8'h5A, 1);
        @(negedge clk);
        check("t6 v_o after reset", u[0].v_o, 0);
        check("t6 bypass accept", u[0].yumi_o, 1);
        check("t6 bypass no fifo op", u[0].fifo_v_o, 0);
        tick(); @(negedge clk);
        check("t6 v_o", u[0].v_o, 1);
        check("t6 data_o", u[0].data_o, 8'h5A);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
